// File: rtl/neuron_lut_prog_pkg.sv
// Shared definitions for the programmable neuron LUT: default geometry
// and the load/inference state encoding.
package neuron_lut_prog_pkg;

    localparam int IN_BITS_DEF  = 6;
    localparam int OUT_BITS_DEF = 2;
    localparam int DEPTH        = 2 ** IN_BITS_DEF;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        LOAD   = 2'd1,
        ACTIVE = 2'd2
    } state_e;

endpackage

// File: rtl/neuron_lut_ram.sv
// Truth-table storage: distributed RAM with one synchronous write port and
// one asynchronous read port. The read result is registered by the parent.
module neuron_lut_ram #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    // Write one entry per accepted config beat.
    // NOTE: the array has no reset; contents are only trusted once a full
    // table has been loaded, and a reset would prevent a distributed-RAM mapping.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/neuron_lut_prog.sv
// Programmable neuron lookup table: a framed config stream loads the full
// truth table, after which each inference request returns its entry one
// cycle later. Framing errors leave the block empty with err raised.
module neuron_lut_prog
    import neuron_lut_prog_pkg::*;
#(
    parameter int IN_BITS  = IN_BITS_DEF,
    parameter int OUT_BITS = OUT_BITS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_start,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [OUT_BITS-1:0] cfg_data,
    input  logic                cfg_last,
    input  logic                in_valid,
    input  logic [IN_BITS-1:0]  in_data,
    output logic                out_valid,
    output logic [OUT_BITS-1:0] out_data,
    output logic                loaded,
    output logic                err
);

    state_e              state_q, state_d;
    logic [IN_BITS-1:0]  idx_q, idx_d;
    logic                loaded_q, loaded_d;
    logic                err_q, err_d;
    logic                out_valid_q, out_valid_d;
    logic [OUT_BITS-1:0] out_data_q, out_data_d;
    logic [OUT_BITS-1:0] rd_data;
    logic                beat;
    logic                at_last;

    // A cfg_start in the same cycle discards the beat so the new load
    // always begins at index 0.
    assign cfg_ready = (state_q == LOAD);
    assign beat      = cfg_valid && cfg_ready && !cfg_start;
    assign at_last   = (idx_q == {IN_BITS{1'b1}});

    neuron_lut_ram #(
        .ADDR_W (IN_BITS),
        .DATA_W (OUT_BITS)
    ) u_ram (
        .clk   (clk),
        .we    (beat),
        .waddr (idx_q),
        .wdata (cfg_data),
        .raddr (in_data),
        .rdata (rd_data)
    );

    // Next-state, write index, status flags and registered inference result.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        loaded_d    = loaded_q;
        err_d       = err_q;
        // The read uses the table as it stands this cycle, so a request that
        // coincides with cfg_start still sees the old contents.
        out_valid_d = in_valid && (state_q == ACTIVE);
        out_data_d  = out_valid_d ? rd_data : out_data_q;

        if (cfg_start) begin
            state_d  = LOAD;
            idx_d    = '0;
            loaded_d = 1'b0;
            err_d    = 1'b0;
        end else if (beat) begin
            if (cfg_last && at_last) begin
                state_d  = ACTIVE;
                loaded_d = 1'b1;
            end else if (cfg_last || at_last) begin
                // Early or missing last marker: the beat is still written,
                // but the table is declared unusable.
                state_d  = EMPTY;
                loaded_d = 1'b0;
                err_d    = 1'b1;
                idx_d    = '0;
            end else begin
                idx_d = idx_q + {{(IN_BITS-1){1'b0}}, 1'b1};
            end
        end
    end

    // State and output registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values computed in the previous combinational pass.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            idx_q       <= '0;
            loaded_q    <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            loaded_q    <= loaded_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign loaded    = loaded_q;
    assign err       = err_q;

endmodule

// File: tb/tb_neuron_lut_prog.sv
// Self-checking bench for neuron_lut_prog: table-driven inference vectors,
// hand-written load sequences and a queue scoreboard on out_valid/out_data.
module tb_neuron_lut_prog;

    localparam int IB = 6;
    localparam int OB = 2;
    localparam int N  = 2 ** IB;

    typedef struct packed {
        logic [IB-1:0] addr;
        logic [OB-1:0] exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_start;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [OB-1:0] cfg_data;
    logic          cfg_last;
    logic          in_valid;
    logic [IB-1:0] in_data;
    logic          out_valid;
    logic [OB-1:0] out_data;
    logic          loaded;
    logic          err;

    int total   = 0;
    int bad     = 0;
    int obs_cnt = 0;

    logic [OB-1:0] model [N];
    logic [OB-1:0] exp_q [$];
    logic [OB-1:0] sb_exp;
    logic [OB-1:0] old_val;
    vec_t          vec [6];
    int            obs_base;

    neuron_lut_prog #(
        .IN_BITS  (IB),
        .OUT_BITS (OB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_data  (cfg_data),
        .cfg_last  (cfg_last),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .loaded    (loaded),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every out_valid must match the oldest pushed expectation.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            obs_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got out_valid=1 data=%0h expected no result", out_data);
            end else begin
                sb_exp = exp_q.pop_front();
                if (out_data !== sb_exp) begin
                    bad++;
                    $display("FAIL sb_out_data: got %0h expected %0h", out_data, sb_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    // One beat; with gaps set, idle cycles carrying junk precede it.
    task automatic send_beat(input logic [OB-1:0] d, input logic last, input bit gaps);
        int ng;
        ng = gaps ? int'($urandom_range(0, 3)) : 0;
        for (int g = 0; g < ng; g++) begin
            cfg_valid = 1'b0;
            cfg_data  = ~d;
            cfg_last  = 1'b1;
            tick();
        end
        cfg_valid = 1'b1;
        cfg_data  = d;
        cfg_last  = last;
        tick();
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
    endtask

    // Stream the whole model table (index already zeroed) and check it lands.
    task automatic full_load(input string tag, input bit gaps);
        for (int i = 0; i < N; i++) begin
            send_beat(model[i], i == N - 1, gaps);
        end
        check({tag, "_loaded"}, loaded, 1);
        check({tag, "_err"}, err, 0);
        check({tag, "_ready"}, cfg_ready, 0);
    endtask

    task automatic infer(input logic [IB-1:0] a, input bit expect_result);
        in_valid = 1'b1;
        in_data  = a;
        if (expect_result) exp_q.push_back(model[a]);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        cfg_last  = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;

        vec[0] = '{addr: 6'd5,  exp: 2'b01};
        vec[1] = '{addr: 6'd0,  exp: 2'b00};
        vec[2] = '{addr: 6'd63, exp: 2'b11};
        vec[3] = '{addr: 6'd10, exp: 2'b10};
        vec[4] = '{addr: 6'd7,  exp: 2'b11};
        vec[5] = '{addr: 6'd62, exp: 2'b10};

        // Reset state
        tick();
        tick();
        check("rst_ready", cfg_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_loaded", loaded, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        tick();

        // Good load with entry i = i[1:0]
        for (int i = 0; i < N; i++) model[i] = OB'(i);
        start_load();
        check("start_ready", cfg_ready, 1);
        check("start_loaded", loaded, 0);
        full_load("load1", 1'b0);

        // Table-driven inference, back-to-back, then hold check
        for (int v = 0; v < 6; v++) begin
            in_valid = 1'b1;
            in_data  = vec[v].addr;
            exp_q.push_back(vec[v].exp);
            tick();
            check("vec_out_valid", out_valid, 1);
            check("vec_out_data", out_data, vec[v].exp);
        end
        in_valid = 1'b0;
        tick();
        check("hold_out_valid", out_valid, 0);
        check("hold_out_data", out_data, 2'b10);

        // Early cfg_last at index 10
        start_load();
        for (int i = 0; i <= 10; i++) send_beat(2'b11, i == 10, 1'b0);
        check("early_err", err, 1);
        check("early_loaded", loaded, 0);
        check("early_ready", cfg_ready, 0);
        infer(6'd5, 1'b0);
        check("early_drop_valid", out_valid, 0);
        check("early_drop_data", out_data, 2'b10);

        // Missing cfg_last at the final index
        start_load();
        check("restart_err_clr", err, 0);
        for (int i = 0; i < N; i++) send_beat(2'b01, 1'b0, 1'b0);
        check("nolast_err", err, 1);
        check("nolast_loaded", loaded, 0);
        check("nolast_ready", cfg_ready, 0);

        // Random table with random cfg_valid gaps, then 64 back-to-back reads
        for (int i = 0; i < N; i++) model[i] = OB'($urandom);
        start_load();
        full_load("gaps", 1'b1);
        obs_base = obs_cnt;
        in_valid = 1'b1;
        for (int i = 0; i < N; i++) begin
            in_data = IB'(i);
            exp_q.push_back(model[i]);
            tick();
            check("b2b_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        tick();
        tick();
        check("b2b_count", obs_cnt - obs_base, N);
        check("b2b_queue_empty", exp_q.size(), 0);

        // cfg_start coinciding with a beat: beat discarded, index zeroed
        start_load();
        for (int i = 0; i < 5; i++) send_beat(2'b10, 1'b0, 1'b0);
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = 2'b11;
        cfg_last  = 1'b0;
        tick();
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        for (int i = 0; i < N; i++) model[i] = OB'(N - 1 - i);
        full_load("restart", 1'b0);
        infer(6'd0, 1'b1);
        infer(6'd33, 1'b1);
        infer(6'd62, 1'b1);

        // cfg_start with in_valid in ACTIVE: result from the old table
        old_val   = model[17];
        cfg_start = 1'b1;
        in_valid  = 1'b1;
        in_data   = 6'd17;
        exp_q.push_back(old_val);
        tick();
        cfg_start = 1'b0;
        check("coinc_valid", out_valid, 1);
        check("coinc_data", out_data, old_val);
        check("coinc_loaded", loaded, 0);
        check("coinc_ready", cfg_ready, 1);
        in_data = 6'd3;
        tick();
        in_valid = 1'b0;
        check("coinc_drop", out_valid, 0);
        for (int i = 0; i < N; i++) model[i] = OB'(i ^ 2);
        full_load("coinc_new", 1'b0);
        infer(6'd17, 1'b1);

        // Reset mid-load at beat 30, then a fresh load
        start_load();
        for (int i = 0; i < 30; i++) send_beat(2'b11, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        check("midrst_loaded", loaded, 0);
        check("midrst_err", err, 0);
        check("midrst_ready", cfg_ready, 0);
        check("midrst_out_valid", out_valid, 0);
        rst = 1'b0;
        tick();
        for (int i = 0; i < N; i++) model[i] = OB'($urandom);
        start_load();
        full_load("fresh", 1'b0);
        infer(6'd1, 1'b1);
        infer(6'd40, 1'b1);
        tick();
        tick();
        check("final_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/neuron_lut_prog.md
NEURON_LUT_PROG -- requirements
Module: neuron_lut_prog

Interface
REQ-001 The block SHALL have parameter IN_BITS, default 6, meaning the neuron LUT address width (fan-in × input bit width).
REQ-002 The block SHALL have parameter OUT_BITS, default 2, meaning the neuron output code width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port cfg_start, input, 1 bit: a one-cycle pulse that begins a new truth-table load.
REQ-006 The block SHALL have port cfg_valid, input, 1 bit: the config beat is valid.
REQ-007 The block SHALL have port cfg_ready, output, 1 bit: the block accepts a config beat.
REQ-008 The block SHALL have port cfg_data, input, OUT_BITS: the LUT entry for the current write index.
REQ-009 The block SHALL have port cfg_last, input, 1 bit: marks the final config beat.
REQ-010 The block SHALL have port in_valid, input, 1 bit: an inference request.
REQ-011 The block SHALL have port in_data, input, IN_BITS: the inference address (concatenated quantised inputs).
REQ-012 The block SHALL have port out_valid, output, 1 bit: the inference result is valid.
REQ-013 The block SHALL have port out_data, output, OUT_BITS: the inference result.
REQ-014 The block SHALL have port loaded, output, 1 bit: a complete, error-free table is resident.
REQ-015 The block SHALL have port err, output, 1 bit: a sticky framing error from the last load.

Function
REQ-016 The block SHALL implement FSM states EMPTY, LOAD, ACTIVE, with EMPTY after reset.
REQ-017 A cfg_start pulse in any state SHALL enter LOAD, zero the write index, and clear loaded and err.
REQ-018 cfg_ready SHALL be 1 only in LOAD.
REQ-019 A beat SHALL transfer when cfg_valid && cfg_ready, writing cfg_data to entry[write index] and incrementing the index.
REQ-020 The index SHALL run 0..2^IN_BITS-1, with entry i the output for in_data == i.
REQ-021 A beat with cfg_last=1 at index 2^IN_BITS-1 SHALL move the FSM to ACTIVE and set loaded=1 on the next cycle.
REQ-022 cfg_last=1 at any other index, or cfg_last=0 at the final index, SHALL set err=1, write that beat, and return the FSM to EMPTY with loaded=0.
REQ-023 The write index SHALL never wrap; the final-index rule in REQ-022 prevents overrun.
REQ-024 Inference in ACTIVE SHALL have 1-cycle latency: out_valid(t+1)=in_valid(t) and out_data(t+1)=entry[in_data(t)].
REQ-025 in_valid outside ACTIVE SHALL be dropped, with out_valid=0 on the next cycle.
REQ-026 cfg_start coinciding with in_valid in ACTIVE SHALL still produce that request's result from the old table; later requests are dropped.
REQ-027 out_data SHALL hold its last value when out_valid=0.
REQ-028 cfg_start coinciding with an accepted beat SHALL take priority: the beat is discarded and the index zeroed.

Reset
REQ-029 rst SHALL force EMPTY, write index 0, cfg_ready=0, out_valid=0, out_data=0, loaded=0, err=0.
REQ-030 LUT contents SHALL be undefined after reset and unobservable until loaded=1.
REQ-031 rst asserted mid-load SHALL abandon the load with no error flagged.

Structure
REQ-032 The shared package SHALL hold IN_BITS/OUT_BITS defaults, DEPTH=2**IN_BITS, and the FSM state enum.
REQ-033 Storage SHALL be sub-module neuron_lut_ram: distributed RAM, 1 synchronous write port, 1 read port, with the output register in the parent.

Verification
REQ-034 Bench SHALL cover: rst, cfg_start, 64 beats with entry i = i[1:0] and last at 63 -> loaded=1, err=0; in_data=6'b000101 -> out_data=2'b01 one cycle later.
REQ-035 Bench SHALL cover: load with cfg_last at index 10 -> err=1, loaded=0, state EMPTY; subsequent in_valid -> out_valid stays 0.
REQ-036 Bench SHALL cover: back-to-back in_valid for addresses 0..63 after a good load -> 64 consecutive out_valid, each matching the model.
REQ-037 Bench SHALL cover: cfg_valid toggled randomly during load -> only handshaked beats write; the final table matches the model.
REQ-038 Bench SHALL cover: cfg_start in the same cycle as in_valid in ACTIVE -> that result comes from the old table, loaded=0 next cycle.
REQ-039 Bench SHALL cover: rst at beat 30 of a load -> loaded=0, err=0, cfg_ready=0; a fresh full load then succeeds.
